type3_unit_arbiter: RTL and testbench

Shares one func_type3 leaf decoder (8-LLR node, two interleaved SPC-4 checks) between two SC decoder lanes, A and B. Arbitration is round-robin with valid/ready handshakes. The output is a single registered stage carrying result bits, source id and tag back to the lanes' result mux. Per-lane saturating grant counters feed the status register file.

---
 rtl/type3_unit_arbiter.sv | 117 +++++++++++
 tb/tb_type3_unit_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/type3_unit_arbiter.sv
// Round-robin arbiter sharing one func_type3 leaf decoder (two interleaved SPC-4
// checks over an 8-LLR node) between SC lanes A and B, with one registered response stage.
module type3_unit_arbiter #(
  parameter int LLR_W   = 6,
  parameter int LLR_NUM = 8,
  parameter int TAG_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [LLR_NUM*LLR_W-1:0] a_llr,
  input  logic [TAG_W-1:0]         a_tag,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [LLR_NUM*LLR_W-1:0] b_llr,
  input  logic [TAG_W-1:0]         b_tag,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_src,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic [LLR_NUM-1:0]       rsp_bits,
  input  logic                     cnt_clr,
  output logic [CNT_W-1:0]         cnt_a,
  output logic [CNT_W-1:0]         cnt_b
);

  logic                     rr_ptr;
  logic                     can_accept;
  logic                     grant_a;
  logic                     grant_b;
  logic                     accept;
  logic [LLR_NUM*LLR_W-1:0] sel_llr;
  logic [LLR_W-1:0]         mag [LLR_NUM];
  logic [LLR_NUM-1:0]       hd;
  logic [LLR_NUM-1:0]       flip;
  logic [LLR_NUM-1:0]       dec_bits;

  // rr_ptr names the lane that wins when both are valid (0 = A).
  assign can_accept = !rsp_valid || rsp_ready;
  assign grant_a    = a_valid && (!b_valid || !rr_ptr);
  assign grant_b    = b_valid && (!a_valid ||  rr_ptr);
  assign a_ready    = rst_n && can_accept && grant_a;
  assign b_ready    = rst_n && can_accept && grant_b;
  assign accept     = a_ready || b_ready;
  assign sel_llr    = grant_b ? b_llr : a_llr;

  // hd/mag/flip are indexed by LLR number; LLR0 sits in the input MSBs and drives the output MSB.
  genvar gi;
  generate
    for (gi = 0; gi < LLR_NUM; gi++) begin : g_llr
      logic signed [LLR_W-1:0] llr;
      assign llr                    = sel_llr[(LLR_NUM-1-gi)*LLR_W +: LLR_W];
      assign hd[gi]                 = llr[LLR_W-1];
      assign mag[gi]                = hd[gi] ? -llr : llr;
      assign dec_bits[LLR_NUM-1-gi] = hd[gi] ^ flip[gi];
    end
  endgenerate

  logic             par;
  logic [LLR_W-1:0] best_mag;
  int               best;

  // Ascending scan with strict '<' makes the lowest index win a magnitude tie.
  always_comb begin
    flip     = '0;
    par      = 1'b0;
    best_mag = '0;
    best     = 0;
    for (int g = 0; g < 2; g++) begin
      par      = 1'b0;
      best     = g;
      best_mag = mag[g];
      for (int k = g; k < LLR_NUM; k += 2) begin
        par = par ^ hd[k];
        if (mag[k] < best_mag) begin
          best_mag = mag[k];
          best     = k;
        end
      end
      if (par) flip[best] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_src   <= 1'b0;
      rsp_tag   <= '0;
      rsp_bits  <= '0;
      rr_ptr    <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_src   <= grant_b;
      rsp_tag   <= grant_b ? b_tag : a_tag;
      rsp_bits  <= dec_bits;
      rr_ptr    <= grant_a;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (cnt_clr) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (a_ready && cnt_a != '1) cnt_a <= cnt_a + 1'b1;
      if (b_ready && cnt_b != '1) cnt_b <= cnt_b + 1'b1;
    end
  end

endmodule

// File: tb/tb_type3_unit_arbiter.sv
// Directed plus randomized checks of type3_unit_arbiter against a behavioural model
// of the arbitration rules, the response register and the SPC-4 leaf decode.
module tb_type3_unit_arbiter;

  localparam int LLR_W   = 6;
  localparam int LLR_NUM = 8;
  localparam int TAG_W   = 4;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     a_valid, b_valid;
  logic                     a_ready, b_ready;
  logic [LLR_NUM*LLR_W-1:0] a_llr, b_llr;
  logic [TAG_W-1:0]         a_tag, b_tag;
  logic                     rsp_valid, rsp_ready, rsp_src;
  logic [TAG_W-1:0]         rsp_tag;
  logic [LLR_NUM-1:0]       rsp_bits;
  logic                     cnt_clr;
  logic [CNT_W-1:0]         cnt_a, cnt_b;

  type3_unit_arbiter #(.LLR_W(LLR_W), .LLR_NUM(LLR_NUM), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_llr(a_llr), .a_tag(a_tag),
    .b_valid(b_valid), .b_ready(b_ready), .b_llr(b_llr), .b_tag(b_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_src(rsp_src),
    .rsp_tag(rsp_tag), .rsp_bits(rsp_bits),
    .cnt_clr(cnt_clr), .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit verbose = 1'b1;

  // Behavioural model state
  bit       m_valid;
  bit       m_src;
  int       m_tag;
  int       m_bits;
  int       m_favour;   // lane that wins a tie: 0 = A, 1 = B
  int       m_cnt_a, m_cnt_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Leaf decode from first principles: hard decisions, then per SPC-4 group
  // fix odd parity by flipping the least reliable member (lowest index on ties).
  function automatic int ref_t3(input logic [LLR_NUM*LLR_W-1:0] v);
    int val [LLR_NUM];
    int bits [LLR_NUM];
    int res;
    for (int i = 0; i < LLR_NUM; i++) begin
      logic signed [LLR_W-1:0] s;
      s = v[(LLR_NUM-1-i)*LLR_W +: LLR_W];
      val[i]  = int'(s);
      bits[i] = (val[i] < 0) ? 1 : 0;
    end
    for (int g = 0; g < 2; g++) begin
      int ones, idx, best;
      ones = 0; idx = -1; best = 1000;
      for (int i = g; i < LLR_NUM; i += 2) begin
        int a;
        ones += bits[i];
        a = (val[i] < 0) ? -val[i] : val[i];
        if (a < best) begin best = a; idx = i; end
      end
      if (ones % 2 == 1) bits[idx] = 1 - bits[idx];
    end
    res = 0;
    for (int i = 0; i < LLR_NUM; i++) res = res * 2 + bits[i];
    return res;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_src = 0; m_tag = 0; m_bits = 0; m_favour = 0;
    m_cnt_a = 0; m_cnt_b = 0;
  endtask

  task automatic check_outputs(input string name);
    chk({name, ":rsp_valid"}, 32'(rsp_valid), 32'(m_valid));
    chk({name, ":rsp_src"},   32'(rsp_src),   32'(m_src));
    chk({name, ":rsp_tag"},   32'(rsp_tag),   32'(m_tag));
    chk({name, ":rsp_bits"},  32'(rsp_bits),  32'(m_bits));
    chk({name, ":cnt_a"},     32'(cnt_a),     32'(m_cnt_a));
    chk({name, ":cnt_b"},     32'(cnt_b),     32'(m_cnt_b));
  endtask

  // One clock: drive at posedge+1, check readies at negedge, check registers at posedge+1.
  task automatic step(input string name,
                      input bit av, input logic [LLR_NUM*LLR_W-1:0] al, input int at,
                      input bit bv, input logic [LLR_NUM*LLR_W-1:0] bl, input int bt,
                      input bit rr, input bit clr);
    bit can, ea, eb;
    a_valid = av; a_llr = al; a_tag = TAG_W'(at);
    b_valid = bv; b_llr = bl; b_tag = TAG_W'(bt);
    rsp_ready = rr; cnt_clr = clr;
    @(negedge clk);
    can = !m_valid || rr;
    ea  = can && av && (!bv || m_favour == 0);
    eb  = can && bv && (!av || m_favour == 1);
    chk({name, ":a_ready"}, 32'(a_ready), 32'(ea));
    chk({name, ":b_ready"}, 32'(b_ready), 32'(eb));
    @(posedge clk);
    if (ea || eb) begin
      m_valid  = 1;
      m_src    = eb;
      m_tag    = eb ? bt : at;
      m_bits   = ref_t3(eb ? bl : al);
      m_favour = ea ? 1 : 0;
    end else if (rr) begin
      m_valid = 0;
    end
    if (clr) begin
      m_cnt_a = 0; m_cnt_b = 0;
    end else begin
      if (ea && m_cnt_a < CNT_MAX) m_cnt_a++;
      if (eb && m_cnt_b < CNT_MAX) m_cnt_b++;
    end
    #1;
    check_outputs(name);
    if (verbose)
      $display("[%0t] %s a=%b/%b b=%b/%b rsp v=%b src=%b tag=%h bits=%h cnt=%0d/%0d",
               $time, name, av, a_ready, bv, b_ready, rsp_valid, rsp_src, rsp_tag,
               rsp_bits, cnt_a, cnt_b);
  endtask

  function automatic logic [LLR_NUM*LLR_W-1:0] rnd_llr();
    return (LLR_NUM*LLR_W)'({$urandom(), $urandom()});
  endfunction

  logic [LLR_NUM*LLR_W-1:0] pos5, pos7, t3a, t3b;

  initial begin
    pos5 = {LLR_NUM{6'sd5}};
    pos7 = {LLR_NUM{6'sd7}};
    t3a  = {-6'sd2, 6'sd7, 6'sd7, 6'sd7, 6'sd7, 6'sd7, 6'sd7, 6'sd7};
    t3b  = {-6'sd2, 6'sd7, -6'sd4, 6'sd7, 6'sd7, 6'sd7, 6'sd7, 6'sd7};

    // Reset state
    rst_n = 1'b0; a_valid = 0; b_valid = 0; a_llr = '0; b_llr = '0;
    a_tag = '0; b_tag = '0; rsp_ready = 0; cnt_clr = 0;
    model_reset();
    #1;
    check_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: A alone, all +5, tag 3
    step("t1_a_alone", 1, pos5, 3, 0, '0, 0, 1, 0);
    chk("t1_bits_const", 32'(rsp_bits), 32'h00);
    chk("t1_cnt_a_const", 32'(cnt_a), 32'd1);

    // 2: both valid, six grants alternate starting with B (A was just granted)
    for (int i = 0; i < 6; i++)
      step("t2_rr", 1, rnd_llr(), i, 1, rnd_llr(), 8 + i, 1, 0);
    chk("t2_cnt_a_const", 32'(cnt_a), 32'd4);
    chk("t2_cnt_b_const", 32'(cnt_b), 32'd3);

    // 3: B datapath corner cases
    step("t3_b_flip", 0, '0, 0, 1, t3a, 5, 1, 0);
    chk("t3_bits_00", 32'(rsp_bits), 32'h00);
    chk("t3_src_b", 32'(rsp_src), 32'd1);
    step("t3_b_even", 0, '0, 0, 1, t3b, 6, 1, 0);
    chk("t3_bits_a0", 32'(rsp_bits), 32'hA0);

    // 4: backpressure holds the response, release accepts with no bubble
    step("t4_load", 1, pos7, 9, 0, '0, 0, 1, 0);
    for (int i = 0; i < 4; i++)
      step("t4_stall", 1, rnd_llr(), 10, 0, '0, 0, 0, 0);
    step("t4_release", 1, t3b, 11, 0, '0, 0, 1, 0);
    chk("t4_tag_new", 32'(rsp_tag), 32'd11);

    // 5: counter saturation and clear priority
    verbose = 1'b0;
    for (int i = 0; i < CNT_MAX + 1; i++)
      step("t5_fill", 1, pos5, i % 16, 0, '0, 0, 1, 0);
    verbose = 1'b1;
    chk("t5_sat", 32'(cnt_a), 32'hFFFF);
    step("t5_sat_hold", 1, pos5, 1, 0, '0, 0, 1, 0);
    step("t5_clr", 1, pos5, 2, 0, '0, 0, 1, 1);
    chk("t5_clr_const", 32'(cnt_a), 32'd0);

    // 6: asynchronous reset while a response is pending
    step("t6_load", 0, '0, 0, 1, pos7, 4, 1, 0);
    a_valid = 1; b_valid = 1; rsp_ready = 1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_async_valid", 32'(rsp_valid), 32'd0);
    check_outputs("t6_reset");
    chk("t6_a_ready_rst", 32'(a_ready), 32'd0);
    chk("t6_b_ready_rst", 32'(b_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("t6_a_first", 1, pos5, 7, 1, pos7, 8, 1, 0);
    chk("t6_src_a", 32'(rsp_src), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom_range(0, 1)), rnd_llr(), int'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), rnd_llr(), int'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
